// File: rtl/vga_sync_gen_pkg.sv
// Shared raster timing description and sizing helper for the VGA sync generator.
package vga_sync_gen_pkg;

  typedef struct packed {
    int unsigned h_active, h_fp, h_sync, h_bp;
    int unsigned v_active, v_fp, v_sync, v_bp;
  } vga_timing_t;

  localparam vga_timing_t VGA_640X480_60 = '{640, 16, 96, 48, 480, 10, 2, 33};

  function automatic int unsigned bits_for(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/vga_sync_gen_axis.sv
// One raster axis: wrapping position counter with active/sync decode and carry-out.
module vga_axis_counter
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter int unsigned W      = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         first_o,
  output logic         active_o,
  output logic         sync_o,
  output logic         carry_o
);

  localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
  // One extra bit keeps the decode bounds exact even when TOTAL == 2**W.
  localparam logic [W:0] ACTIVE_END = (W+1)'(ACTIVE);
  localparam logic [W:0] SYNC_BEG   = (W+1)'(ACTIVE + FP);
  localparam logic [W:0] SYNC_END   = (W+1)'(ACTIVE + FP + SYNC);
  localparam logic [W:0] LAST       = (W+1)'(TOTAL - 1);

  logic [W-1:0] count_q, count_d;
  logic [W:0]   count_x;
  logic         last;

  assign count_x  = {1'b0, count_q};
  assign last     = (count_x == LAST);
  assign first_o  = (count_q == '0);
  assign active_o = (count_x < ACTIVE_END);
  assign sync_o   = (count_x >= SYNC_BEG) && (count_x < SYNC_END);
  assign carry_o  = en_i && last;
  assign count_o  = count_q;

  always_comb begin
    count_d = count_q;
    if (en_i) count_d = last ? '0 : count_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

endmodule

// File: rtl/vga_sync_gen.sv
// Parametrised raster timing generator: registered sync/blank, lookahead coordinates,
// line/frame strobes and a completed-frame counter, advancing on pix_en ticks.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_640X480_60.h_active,
  parameter int unsigned H_FP     = VGA_640X480_60.h_fp,
  parameter int unsigned H_SYNC   = VGA_640X480_60.h_sync,
  parameter int unsigned H_BP     = VGA_640X480_60.h_bp,
  parameter int unsigned V_ACTIVE = VGA_640X480_60.v_active,
  parameter int unsigned V_FP     = VGA_640X480_60.v_fp,
  parameter int unsigned V_SYNC   = VGA_640X480_60.v_sync,
  parameter int unsigned V_BP     = VGA_640X480_60.v_bp,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned PREFETCH = 0,
  parameter int unsigned COORD_W  = 10,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               pix_en,
  output logic               hs,
  output logic               vs,
  output logic               blank,
  output logic [COORD_W-1:0] current_x,
  output logic [COORD_W-1:0] current_y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0 ||
      PREFETCH >= H_ACTIVE ||
      bits_for(H_TOTAL - 1) > COORD_W || bits_for(V_TOTAL - 1) > COORD_W) begin : g_bad_params
    $error("vga_sync_gen: illegal timing parameters");
  end

  logic [COORD_W-1:0] h_count, v_count;
  logic h_first, h_active, h_sync, h_carry;
  logic v_first, v_active, v_sync, v_carry;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(COORD_W)
  ) u_h (
    .clk_i(clk), .rst_ni(resetn), .en_i(pix_en),
    .count_o(h_count), .first_o(h_first), .active_o(h_active),
    .sync_o(h_sync), .carry_o(h_carry)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(COORD_W)
  ) u_v (
    .clk_i(clk), .rst_ni(resetn), .en_i(h_carry),
    .count_o(v_count), .first_o(v_first), .active_o(v_active),
    .sync_o(v_sync), .carry_o(v_carry)
  );

  // Lookahead: PREFETCH < H_TOTAL, so a single compare/subtract covers the line wrap.
  logic [COORD_W:0]   x_sum;
  logic               x_wrap;
  logic [COORD_W-1:0] x_ahead, y_ahead;

  always_comb begin
    x_sum   = {1'b0, h_count} + (COORD_W+1)'(PREFETCH);
    x_wrap  = (x_sum >= (COORD_W+1)'(H_TOTAL));
    x_ahead = x_sum[COORD_W-1:0];
    y_ahead = v_count;
    if (x_wrap) begin
      x_ahead = COORD_W'(x_sum - (COORD_W+1)'(H_TOTAL));
      y_ahead = (v_count == COORD_W'(V_TOTAL - 1)) ? '0 : v_count + COORD_W'(1);
    end
  end

  logic               hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               line_q, line_d, frame_q, frame_d;
  logic [FRAME_W-1:0] fcount_q, fcount_d;
  logic               done_q, done_d;

  // done_q marks that a full frame has wrapped, so the post-reset (0,0) is not counted.
  always_comb begin
    hs_d     = hs_q;
    vs_d     = vs_q;
    blank_d  = blank_q;
    x_d      = x_q;
    y_d      = y_q;
    line_d   = 1'b0;
    frame_d  = 1'b0;
    fcount_d = fcount_q;
    done_d   = done_q || v_carry;
    if (pix_en) begin
      hs_d    = h_sync ? HS_POL : ~HS_POL;
      vs_d    = v_sync ? VS_POL : ~VS_POL;
      blank_d = !(h_active && v_active);
      x_d     = x_ahead;
      y_d     = y_ahead;
      line_d  = h_first;
      frame_d = h_first && v_first;
      if (h_first && v_first && done_q) fcount_d = fcount_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      blank_q  <= 1'b1;
      x_q      <= '0;
      y_q      <= '0;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      fcount_q <= '0;
      done_q   <= 1'b0;
    end else begin
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      blank_q  <= blank_d;
      x_q      <= x_d;
      y_q      <= y_d;
      line_q   <= line_d;
      frame_q  <= frame_d;
      fcount_q <= fcount_d;
      done_q   <= done_d;
    end
  end

  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign current_x   = x_q;
  assign current_y   = y_q;
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign frame_count = fcount_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: small timings for frame walks, default 640x480 for rate checks.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic pix_en = 1'b0;
  logic pix_en_d = 1'b0;
  int unsigned checks = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  logic s_hs, s_vs, s_blank, s_ls, s_fs;
  logic [3:0] s_cx, s_cy;
  logic [15:0] s_fc;
  logic p_hs, p_vs, p_blank, p_ls, p_fs;
  logic [3:0] p_cx, p_cy;
  logic [15:0] p_fc;
  logic i_hs, i_vs, i_blank, i_ls, i_fs;
  logic [3:0] i_cx, i_cy;
  logic [1:0] i_fc;
  logic d_hs, d_vs, d_blank, d_ls, d_fs;
  logic [9:0] d_cx, d_cy;
  logic [15:0] d_fc;

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PREFETCH(0), .COORD_W(4), .FRAME_W(16)
  ) dut_s (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .hs(s_hs), .vs(s_vs), .blank(s_blank),
    .current_x(s_cx), .current_y(s_cy), .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PREFETCH(3), .COORD_W(4), .FRAME_W(16)
  ) dut_p (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .hs(p_hs), .vs(p_vs), .blank(p_blank),
    .current_x(p_cx), .current_y(p_cy), .line_start(p_ls), .frame_start(p_fs), .frame_count(p_fc)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .PREFETCH(0), .COORD_W(4), .FRAME_W(2)
  ) dut_i (
    .clk(clk), .resetn(resetn), .pix_en(pix_en), .hs(i_hs), .vs(i_vs), .blank(i_blank),
    .current_x(i_cx), .current_y(i_cy), .line_start(i_ls), .frame_start(i_fs), .frame_count(i_fc)
  );

  vga_sync_gen dut_d (
    .clk(clk), .resetn(resetn), .pix_en(pix_en_d), .hs(d_hs), .vs(d_vs), .blank(d_blank),
    .current_x(d_cx), .current_y(d_cy), .line_start(d_ls), .frame_start(d_fs), .frame_count(d_fc)
  );

  // Expected {hs, vs, blank} for the 8/2/2/2 x 4/1/1/1 timing.
  function automatic logic [2:0] lvl(input int x, input int y, input logic pol);
    logic h, v, b;
    h = (x >= 10 && x < 12) ? pol : ~pol;
    v = (y == 5) ? pol : ~pol;
    b = (x >= 8) || (y >= 4);
    return {h, v, b};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_all;
    @(posedge clk); #1;
    resetn = 1'b0; pix_en = 1'b0; pix_en_d = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    logic [28:0] got, want;
    @(posedge clk); #1;
    resetn = 1'b0; pix_en = 1'b1; pix_en_d = 1'b0;
    #2;
    got  = {s_hs, s_vs, s_blank, s_cx, s_cy, s_ls, s_fs, s_fc};
    want = {1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 16'd0};
    checks++;
    if (got !== want) $display("FAIL reset_values got %h want %h", got, want); else passed++;
    checks++;
    if ({i_hs, i_vs, i_blank, i_fc} !== 5'b00100)
      $display("FAIL reset_inverted got %b want 00100", {i_hs, i_vs, i_blank, i_fc});
    else passed++;
    checks++;
    if ({d_hs, d_vs, d_blank, d_cx, d_cy, d_fc} !== {3'b111, 10'd0, 10'd0, 16'd0})
      $display("FAIL reset_default got %h", {d_hs, d_vs, d_blank, d_cx, d_cy, d_fc});
    else passed++;
    @(posedge clk); #1;
    resetn = 1'b1; pix_en = 1'b0;
    tick();
    got = {s_hs, s_vs, s_blank, s_cx, s_cy, s_ls, s_fs, s_fc};
    checks++;
    if (got !== want) $display("FAIL reset_hold got %h want %h", got, want); else passed++;
    pix_en = 1'b1;
    tick();
    got  = {s_hs, s_vs, s_blank, s_cx, s_cy, s_ls, s_fs, s_fc};
    want = {1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 16'd0};
    checks++;
    if (got !== want) $display("FAIL first_pixel got %h want %h", got, want); else passed++;
  endtask

  task automatic test_frame_walk;
    logic [28:0] got, want;
    int x, y;
    start_all();
    for (int k = 0; k < 98; k++) begin
      if (k > 0) tick();
      x = k % 14;
      y = k / 14;
      got  = {s_hs, s_vs, s_blank, s_cx, s_cy, s_ls, s_fs, s_fc};
      want = {lvl(x, y, 1'b0), x[3:0], y[3:0], (x == 0), (k == 0), 16'd0};
      checks++;
      if (got !== want) $display("FAIL frame_walk k=%0d got %h want %h", k, got, want); else passed++;
    end
    tick();
    got  = {s_hs, s_vs, s_blank, s_cx, s_cy, s_ls, s_fs, s_fc};
    want = {1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 16'd1};
    checks++;
    if (got !== want) $display("FAIL frame_period got %h want %h", got, want); else passed++;
  endtask

  task automatic test_prefetch;
    logic [28:0] got, want;
    int x, y, px, py;
    start_all();
    for (int k = 0; k < 98; k++) begin
      if (k > 0) tick();
      x = k % 14;
      y = k / 14;
      px = x + 3;
      py = y;
      if (px >= 14) begin
        px = px - 14;
        py = (y + 1) % 7;
      end
      got  = {p_hs, p_vs, p_blank, p_cx, p_cy, p_ls, p_fs, p_fc};
      want = {lvl(x, y, 1'b0), px[3:0], py[3:0], (x == 0), (k == 0), 16'd0};
      checks++;
      if (got !== want) $display("FAIL prefetch_walk k=%0d got %h want %h", k, got, want); else passed++;
      if (k == 0) begin
        checks++;
        if ({p_cx, p_cy} !== {4'd3, 4'd0}) $display("FAIL prefetch_origin got %h want 30", {p_cx, p_cy});
        else passed++;
      end
      if (k == 96) begin
        checks++;
        if ({p_cx, p_cy} !== {4'd1, 4'd0}) $display("FAIL prefetch_frame_wrap got %h want 10", {p_cx, p_cy});
        else passed++;
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [28:0] got, want;
    start_all();
    repeat (98 + 33) tick();
    checks++;
    if ({s_cx, s_cy, s_fc} !== {4'd5, 4'd2, 16'd1})
      $display("FAIL pre_reset_pos got %h want 520001", {s_cx, s_cy, s_fc});
    else passed++;
    resetn = 1'b0;
    #2;
    got  = {s_hs, s_vs, s_blank, s_cx, s_cy, s_ls, s_fs, s_fc};
    want = {1'b1, 1'b1, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 16'd0};
    checks++;
    if (got !== want) $display("FAIL async_reset got %h want %h", got, want); else passed++;
    @(posedge clk); #1;
    resetn = 1'b1;
    tick();
    got  = {s_hs, s_vs, s_blank, s_cx, s_cy, s_ls, s_fs, s_fc};
    want = {1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 16'd0};
    checks++;
    if (got !== want) $display("FAIL restart got %h want %h", got, want); else passed++;
    tick();
    got  = {s_hs, s_vs, s_blank, s_cx, s_cy, s_ls, s_fs, s_fc};
    want = {1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0, 16'd0};
    checks++;
    if (got !== want) $display("FAIL restart_next got %h want %h", got, want); else passed++;
  endtask

  task automatic test_polarity;
    logic [11:0] got, want;
    int x, y;
    start_all();
    for (int k = 0; k < 98; k++) begin
      if (k > 0) tick();
      x = k % 14;
      y = k / 14;
      got  = {i_hs, i_vs, i_blank, i_cx, i_cy, i_ls};
      want = {lvl(x, y, 1'b1), x[3:0], y[3:0], (x == 0)};
      checks++;
      if (got !== want) $display("FAIL polarity_walk k=%0d got %h want %h", k, got, want); else passed++;
    end
    for (int f = 1; f <= 4; f++) begin
      repeat ((f == 1) ? 1 : 98) tick();
      checks++;
      if ({i_fs, i_fc} !== {1'b1, 2'(f % 4)})
        $display("FAIL frame_count_wrap f=%0d got %b want %b", f, {i_fs, i_fc}, {1'b1, 2'(f % 4)});
      else passed++;
    end
  endtask

  task automatic test_default_rate;
    logic [22:0] prev;
    logic prev_ls, prev_fs, prev_hs;
    int ls_n, hf_n, fs_n, bad_width, unstable, vs_low, last_ls, last_hf;
    ls_n = 0; hf_n = 0; fs_n = 0; bad_width = 0; unstable = 0; vs_low = 0;
    last_ls = -1; last_hf = -1;
    @(posedge clk); #1;
    resetn = 1'b0; pix_en = 1'b0; pix_en_d = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int c = 0; c < 9700; c++) begin
      pix_en_d = (c % 4 == 0);
      prev    = {d_hs, d_vs, d_blank, d_cx, d_cy};
      prev_ls = d_ls;
      prev_fs = d_fs;
      prev_hs = d_hs;
      tick();
      if (!pix_en_d && ({d_hs, d_vs, d_blank, d_cx, d_cy} !== prev)) unstable++;
      if (d_ls) begin
        if (prev_ls) bad_width++;
        if (last_ls >= 0) begin
          checks++;
          if (c - last_ls != 3200) $display("FAIL line_period got %0d want 3200", c - last_ls);
          else passed++;
        end
        ls_n++;
        last_ls = c;
      end
      if (prev_hs && !d_hs) begin
        checks++;
        if (hf_n == 0) begin
          if (c != 2624) $display("FAIL hs_first_edge got %0d want 2624", c); else passed++;
        end else begin
          if (c - last_hf != 3200) $display("FAIL hs_period got %0d want 3200", c - last_hf); else passed++;
        end
        hf_n++;
        last_hf = c;
      end
      if (d_fs) begin
        if (prev_fs) bad_width++;
        fs_n++;
      end
      if (!d_vs) vs_low++;
    end
    pix_en_d = 1'b0;
    checks++;
    if ({ls_n, hf_n, fs_n} != {32'd4, 32'd3, 32'd1})
      $display("FAIL strobe_counts got ls=%0d hf=%0d fs=%0d want 4 3 1", ls_n, hf_n, fs_n);
    else passed++;
    checks++;
    if (bad_width != 0) $display("FAIL strobe_width got %0d wide pulses want 0", bad_width); else passed++;
    checks++;
    if (unstable != 0) $display("FAIL level_hold got %0d changes want 0", unstable); else passed++;
    checks++;
    if (vs_low != 0) $display("FAIL vs_idle got %0d low cycles want 0", vs_low); else passed++;
    checks++;
    if ({d_cx, d_cy, d_blank, d_fc} !== {10'd24, 10'd3, 1'b0, 16'd0})
      $display("FAIL default_position got x=%0d y=%0d blank=%b fc=%0d want 24 3 0 0", d_cx, d_cy, d_blank, d_fc);
    else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_frame_walk();
    test_prefetch();
    test_reset_midframe();
    test_polarity();
    test_default_rate();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
